adc_xy_fb_sched: RTL

//  Triple-buffer frame scheduler for the ADC-XY -> SRAM framebuffer -> VGA path.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/fb_clear_seq.sv | 61 ++++++
 rtl/adc_xy_fb_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the triple-buffered ADC-XY framebuffer scheduler.
package fb_pkg;

  typedef logic [1:0] fb_idx_t;

  localparam int unsigned FB_WIDTH_DFLT  = 32'd640;
  localparam int unsigned FB_HEIGHT_DFLT = 32'd480;
  localparam int unsigned FB_PIXELS      = FB_WIDTH_DFLT * FB_HEIGHT_DFLT;

  typedef enum logic [0:0] {
    FB_CLEAR = 1'b0,
    FB_WRITE = 1'b1
  } fb_state_e;

  // Buffers are packed back to back, so a buffer's base is its index times its size.
  function automatic logic [31:0] fb_base(input fb_idx_t idx, input int unsigned pixels);
    return 32'(idx) * pixels;
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Walks one framebuffer's address range issuing clear writes over a valid/ready stream.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32'd20,
  parameter int unsigned PIXELS = FB_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              done_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              hs;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    last_d  = last_q;
    done_o  = 1'b0;
    hs      = valid_q && ready_i;
    if (start_i) begin
      valid_d = 1'b1;
      addr_d  = base_i;
      last_d  = base_i + ADDR_W'(PIXELS - 32'd1);
    end else if (hs) begin
      // Final accepted write closes the range; the address is left on the last word.
      if (addr_q == last_q) begin
        valid_d = 1'b0;
        done_o  = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      last_q  <= ADDR_W'(PIXELS - 32'd1);
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/adc_xy_fb_sched.sv
// Triple-buffer scheduler: rotates write/display/pending buffers and clears each new write buffer.
module adc_xy_fb_sched
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH       = FB_WIDTH_DFLT,
  parameter int unsigned FB_HEIGHT      = FB_HEIGHT_DFLT,
  parameter int unsigned AXI_ADDR_WIDTH = 32'd20,
  parameter int unsigned CNT_BITS       = 32'd16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_frame_done,
  input  logic                      rd_frame_start,
  output logic                      clr_valid,
  input  logic                      clr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] clr_addr,
  output logic                      wr_en,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base,
  output logic [AXI_ADDR_WIDTH-1:0] rd_base,
  output logic                      pend_valid,
  output logic [CNT_BITS-1:0]       frames_dropped
);

  localparam int unsigned PIXELS = FB_WIDTH * FB_HEIGHT;

  function automatic logic [AXI_ADDR_WIDTH-1:0] base_of(input fb_idx_t idx);
    return AXI_ADDR_WIDTH'(fb_base(idx, PIXELS));
  endfunction

  fb_state_e                 state_q, state_d;
  fb_idx_t                   w_q, w_d, r_q, r_d, p_q, p_d;
  logic                      pend_q, pend_d;
  logic [CNT_BITS-1:0]       drop_q, drop_d;
  logic                      wr_en_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_base_q, rd_base_q;
  logic                      kick_q;
  logic                      wr_evt, rd_evt, clr_start, clr_done;
  logic [AXI_ADDR_WIDTH-1:0] clr_base;

  always_comb begin
    wr_evt = wr_frame_done && (state_q == FB_WRITE);
    rd_evt = rd_frame_start;
    w_d    = w_q;
    r_d    = r_q;
    p_d    = p_q;
    pend_d = pend_q;
    case ({wr_evt, rd_evt})
      2'b11: begin
        r_d    = w_q;
        w_d    = p_q;
        p_d    = r_q;
        pend_d = 1'b0;
      end
      2'b10: begin
        w_d    = p_q;
        p_d    = w_q;
        pend_d = 1'b1;
      end
      2'b01: begin
        // Without a pending frame the reader simply redisplays its current buffer.
        if (pend_q) begin
          r_d    = p_q;
          p_d    = r_q;
          pend_d = 1'b0;
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        pend_d = pend_q;
      end
    endcase
    if (wr_evt && pend_q && (drop_q != {CNT_BITS{1'b1}})) begin
      drop_d = drop_q + CNT_BITS'(1);
    end else begin
      drop_d = drop_q;
    end
    clr_start = kick_q | wr_evt;
    clr_base  = base_of(w_d);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_CLEAR: begin
        if (clr_done) state_d = FB_WRITE;
        else          state_d = FB_CLEAR;
      end
      FB_WRITE: begin
        if (wr_evt) state_d = FB_CLEAR;
        else        state_d = FB_WRITE;
      end
      default: state_d = FB_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FB_CLEAR;
      w_q       <= 2'd0;
      r_q       <= 2'd1;
      p_q       <= 2'd2;
      pend_q    <= 1'b0;
      drop_q    <= {CNT_BITS{1'b0}};
      wr_en_q   <= 1'b0;
      wr_base_q <= base_of(2'd0);
      rd_base_q <= base_of(2'd1);
      kick_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      r_q       <= r_d;
      p_q       <= p_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      wr_en_q   <= (state_d == FB_WRITE);
      wr_base_q <= base_of(w_d);
      rd_base_q <= base_of(r_d);
      kick_q    <= 1'b0;
    end
  end

  fb_clear_seq #(
    .ADDR_W (AXI_ADDR_WIDTH),
    .PIXELS (PIXELS)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .start_i (clr_start),
    .base_i  (clr_base),
    .ready_i (clr_ready),
    .valid_o (clr_valid),
    .addr_o  (clr_addr),
    .done_o  (clr_done)
  );

  assign wr_en          = wr_en_q;
  assign wr_base        = wr_base_q;
  assign rd_base        = rd_base_q;
  assign pend_valid     = pend_q;
  assign frames_dropped = drop_q;

endmodule
